telemetry_counter_bank: RTL and testbench

- Parametrised successor to the fixed mcycle/minstret/stall telemetry counters in the RISC-V core.
- Holds NUM_CH generic event counters of CNT_W bits each, with:
  - per-channel enable
  - sticky overflow flags
  - atomic snapshot into shadow registers
  - global clear
- Software accesses it through a single-cycle MMIO slave port, the same dport request/ack shape used by the data-port mux.
- Sits beside riscv_core on the dport MMIO decode. Event inputs come from the core, e.g. ch0 = 1 for cycles, ch1 = retire, ch2 = stall.

---
 rtl/telemetry_pkg.sv | 27 ++
 rtl/telemetry_counter_bank_if.sv | 20 ++
 rtl/tlm_counter_cell.sv | 42 ++++
 rtl/telemetry_counter_bank.sv | 150 +++++++++++++++
 tb/tb_telemetry_counter_bank.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/telemetry_pkg.sv
// Shared register map, CTRL layout and address helper for the telemetry counter bank.
package telemetry_pkg;

  localparam int unsigned RegCtrl         = 'h00;
  localparam int unsigned RegChEn         = 'h04;
  localparam int unsigned RegOvf          = 'h08;
  localparam int unsigned RegIrqEn        = 'h0C;
  localparam int unsigned RegShadowBase   = 'h10;
  localparam int unsigned RegShadowStride = 8;

  localparam int unsigned CtrlGenBit  = 0;
  localparam int unsigned CtrlSnapBit = 1;
  localparam int unsigned CtrlClrBit  = 2;

  typedef struct packed {
    logic [28:0] rsvd;
    logic        clr;
    logic        snap;
    logic        gen;
  } ctrl_t;

  // Word-aligned match; the byte lane bits of the address are ignored.
  function automatic logic offset_hit(logic [7:0] addr, int unsigned off);
    return addr[7:2] == 6'(off >> 2);
  endfunction

endpackage

// File: rtl/telemetry_counter_bank_if.sv
// Single-cycle MMIO request/ack port, same shape as the core data port.
interface telemetry_counter_bank_if;
  logic [7:0]  mem_addr_i;
  logic        mem_rd_i;
  logic [3:0]  mem_wr_i;
  logic [31:0] mem_data_wr_i;
  logic        mem_accept_o;
  logic        mem_ack_o;
  logic [31:0] mem_data_rd_o;

  modport master (
    output mem_addr_i, mem_rd_i, mem_wr_i, mem_data_wr_i,
    input  mem_accept_o, mem_ack_o, mem_data_rd_o
  );

  modport slave (
    input  mem_addr_i, mem_rd_i, mem_wr_i, mem_data_wr_i,
    output mem_accept_o, mem_ack_o, mem_data_rd_o
  );
endinterface

// File: rtl/tlm_counter_cell.sv
// One free-running event counter with its snapshot shadow register.
module tlm_counter_cell #(
  parameter int unsigned CNT_W = 48
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] shadow,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q;

  // A clear swallows a coincident increment, so it cannot wrap either.
  assign wrap   = inc & ~clr & (&cnt_q);
  assign shadow = shadow_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (snap) begin
        shadow_q <= cnt_q;
      end
    end
  end

endmodule

// File: rtl/telemetry_counter_bank.sv
// Bank of NUM_CH event counters with snapshot shadows, sticky overflow and MMIO access.
// Optional overflow interrupt (IRQ_EN register and irq_o) is built when TLM_IRQ_EN is defined.
module telemetry_counter_bank
  import telemetry_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 48
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_CH-1:0]     event_i,
  telemetry_counter_bank_if.slave mem,
  output logic [NUM_CH-1:0]     ovf_o
`ifdef TLM_IRQ_EN
  ,
  output logic                  irq_o
`endif
);

  logic              wr_en, rd_en, req;
  logic              wr_ctrl, wr_chen, wr_ovf;
  logic              snap, clr;
  ctrl_t             ctrl_wr, ctrl_rd;
  logic              gen_q, gen_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] inc, wrap;
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [63:0]       sh_ext [NUM_CH];
  logic [31:0]       rdata, data_q;
  logic              ack_q;

  assign ctrl_wr = ctrl_t'(mem.mem_data_wr_i);
  assign wr_en   = |mem.mem_wr_i;
  // Write wins over a simultaneous read; either way one ack.
  assign rd_en   = mem.mem_rd_i & ~wr_en;
  assign req     = mem.mem_rd_i | wr_en;

  assign wr_ctrl = wr_en & offset_hit(mem.mem_addr_i, RegCtrl);
  assign wr_chen = wr_en & offset_hit(mem.mem_addr_i, RegChEn);
  assign wr_ovf  = wr_en & offset_hit(mem.mem_addr_i, RegOvf);
  assign snap    = wr_ctrl & ctrl_wr.snap;
  assign clr     = wr_ctrl & ctrl_wr.clr;

  assign inc = event_i & en_q & {NUM_CH{gen_q}};

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_cell
    tlm_counter_cell #(
      .CNT_W (CNT_W)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc    (inc[g]),
      .clr    (clr),
      .snap   (snap),
      .shadow (shadow[g]),
      .wrap   (wrap[g])
    );
    assign sh_ext[g] = 64'(shadow[g]);
  end

  always_comb begin
    gen_d = gen_q;
    en_d  = en_q;
    ovf_d = ovf_q;
    if (wr_ctrl) begin
      gen_d = ctrl_wr.gen;
    end
    if (wr_chen) begin
      en_d = mem.mem_data_wr_i[NUM_CH-1:0];
    end
    if (wr_ovf) begin
      ovf_d = ovf_d & ~mem.mem_data_wr_i[NUM_CH-1:0];
    end
    if (clr) begin
      ovf_d = '0;
    end
    // Applied last so a fresh overflow beats a coincident W1C.
    ovf_d = ovf_d | wrap;
  end

`ifdef TLM_IRQ_EN
  logic [NUM_CH-1:0] irq_en_q;
  logic              irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && offset_hit(mem.mem_addr_i, RegIrqEn)) begin
        irq_en_q <= mem.mem_data_wr_i[NUM_CH-1:0];
      end
      irq_q <= |(ovf_q & irq_en_q);
    end
  end

  assign irq_o = irq_q;
`endif

  always_comb begin
    rdata       = '0;
    ctrl_rd     = '0;
    ctrl_rd.gen = gen_q;
    if (offset_hit(mem.mem_addr_i, RegCtrl)) begin
      rdata = ctrl_rd;
    end else if (offset_hit(mem.mem_addr_i, RegChEn)) begin
      rdata = 32'(en_q);
    end else if (offset_hit(mem.mem_addr_i, RegOvf)) begin
      rdata = 32'(ovf_q);
`ifdef TLM_IRQ_EN
    end else if (offset_hit(mem.mem_addr_i, RegIrqEn)) begin
      rdata = 32'(irq_en_q);
`endif
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (offset_hit(mem.mem_addr_i, RegShadowBase + RegShadowStride * i)) begin
        rdata = sh_ext[i][31:0];
      end
      if (offset_hit(mem.mem_addr_i, RegShadowBase + RegShadowStride * i + 4)) begin
        rdata = sh_ext[i][63:32];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gen_q  <= 1'b0;
      en_q   <= '0;
      ovf_q  <= '0;
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      gen_q  <= gen_d;
      en_q   <= en_d;
      ovf_q  <= ovf_d;
      ack_q  <= req;
      data_q <= rd_en ? rdata : '0;
    end
  end

  assign mem.mem_accept_o  = 1'b1;
  assign mem.mem_ack_o     = ack_q;
  assign mem.mem_data_rd_o = data_q;
  assign ovf_o             = ovf_q;

  logic unused_bits;
  assign unused_bits = ^{mem.mem_addr_i[1:0], ctrl_wr.rsvd, mem.mem_data_wr_i};

endmodule

// File: tb/tb_telemetry_counter_bank.sv
// Directed bench for telemetry_counter_bank (NUM_CH=4, CNT_W=16) with a read-data scoreboard.
module tb_telemetry_counter_bank;
  import telemetry_pkg::*;

  localparam logic [7:0] A_CTRL  = 8'h00;
  localparam logic [7:0] A_CHEN  = 8'h04;
  localparam logic [7:0] A_OVF   = 8'h08;
  localparam logic [7:0] A_IRQEN = 8'h0C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ev;
  logic [3:0] ovf;
`ifdef TLM_IRQ_EN
  logic       irq;
`endif

  always #5 clk = ~clk;

  telemetry_counter_bank_if bus ();

  telemetry_counter_bank #(
    .NUM_CH (4),
    .CNT_W  (16)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .event_i (ev),
    .mem     (bus),
    .ovf_o   (ovf)
`ifdef TLM_IRQ_EN
    ,
    .irq_o   (irq)
`endif
  );

  typedef struct {
    logic [31:0] exp;
    bit          is_rd;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
    bus.mem_addr_i = a;
    bus.mem_rd_i   = 1'b1;
    sb.push_back('{exp: e, is_rd: 1'b1, tag: tag});
    @(negedge clk);
    bus.mem_rd_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.mem_addr_i    = a;
    bus.mem_wr_i      = 4'hF;
    bus.mem_data_wr_i = d;
    sb.push_back('{exp: 32'h0, is_rd: 1'b0, tag: "wr_ack"});
    @(negedge clk);
    bus.mem_wr_i = 4'h0;
  endtask

  // Every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.mem_ack_o) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'(bus.mem_ack_o), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rd) chk(e.tag, bus.mem_data_rd_o, e.exp);
      end
    end
  end

  initial begin
    rst_n             = 1'b0;
    ev                = '0;
    bus.mem_addr_i    = '0;
    bus.mem_rd_i      = 1'b0;
    bus.mem_wr_i      = '0;
    bus.mem_data_wr_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.mem_ack_o), 32'h0);
    chk("rst_rdata", bus.mem_data_rd_o, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("accept", 32'(bus.mem_accept_o), 32'h1);
    rst_n = 1'b1;

    rd(A_CTRL, 32'h0, "ctrl_rst");
    rd(A_CHEN, 32'h0, "chen_rst");
    rd(A_OVF, 32'h0, "ovf_rst");
    rd(8'h10, 32'h0, "sh0_rst");
    rd(A_IRQEN, 32'h0, "irqen_rst");

    // 100 enabled events on ch0; ch1 strobes but is disabled.
    wr(A_CHEN, 32'h1);
    wr(A_CTRL, 32'h1);
    ev = 4'b0011;
    repeat (100) @(negedge clk);
    ev = '0;
    wr(A_CTRL, 32'h3);
    rd(8'h10, 32'd100, "sh0_lo_100");
    rd(8'h14, 32'h0, "sh0_hi_100");
    rd(8'h18, 32'h0, "sh1_disabled");
    rd(A_CTRL, 32'h1, "ctrl_pulses_read0");

    // Unmapped write ignored, then back-to-back reads.
    wr(8'h40, 32'hFFFF_FFFF);
    rd(A_CHEN, 32'h1, "b2b_chen");
    rd(A_OVF, 32'h0, "b2b_ovf");
    rd(8'h40, 32'h0, "b2b_unmapped");

    // CLR coincident with an event at count 5.
    wr(A_CHEN, 32'h2);
    ev = 4'b0010;
    repeat (5) @(negedge clk);
    wr(A_CTRL, 32'h5);
    ev = '0;
    wr(A_CTRL, 32'h3);
    rd(8'h18, 32'h0, "clr_beats_event");
    ev = 4'b0010;
    repeat (5) @(negedge clk);
    ev = '0;
    wr(A_CTRL, 32'h7);
    rd(8'h18, 32'd5, "snap_clr_pre");
    wr(A_CTRL, 32'h3);
    rd(8'h18, 32'h0, "snap_clr_post");

    // Drive ch0 and ch2 to all-ones, then wrap them separately.
    wr(A_CTRL, 32'h5);
    wr(A_CHEN, 32'h5);
    wr(A_IRQEN, 32'h4);
`ifdef TLM_IRQ_EN
    rd(A_IRQEN, 32'h4, "irqen_rw");
`else
    rd(A_IRQEN, 32'h0, "irqen_absent");
`endif
    ev = 4'b0101;
    repeat (65535) @(negedge clk);
    ev = '0;
    wr(A_CTRL, 32'h3);
    rd(8'h10, 32'hFFFF, "sh0_allones");
    rd(8'h20, 32'hFFFF, "sh2_allones");
    rd(A_OVF, 32'h0, "ovf_before_wrap");
    chk("ovf_o_before_wrap", 32'(ovf), 32'h0);

    ev = 4'b0001;
    wr(A_OVF, 32'h1);
    ev = '0;
    chk("ovf_set_beats_w1c", 32'(ovf), 32'h1);

    ev = 4'b0100;
    @(negedge clk);
    ev = '0;
    chk("ovf_ch2_wrap", 32'(ovf), 32'h5);
`ifdef TLM_IRQ_EN
    chk("irq_latency", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'h1);
`endif
    wr(A_CTRL, 32'h3);
    rd(8'h10, 32'h0, "sh0_wrapped");
    rd(8'h14, 32'h0, "sh0_hi_wrapped");
    rd(8'h20, 32'h0, "sh2_wrapped");
    rd(A_OVF, 32'h5, "ovf_after_wrap");

    wr(A_OVF, 32'h4);
    rd(A_OVF, 32'h1, "ovf_w1c");
    chk("ovf_o_w1c", 32'(ovf), 32'h1);
`ifdef TLM_IRQ_EN
    chk("irq_cleared", 32'(irq), 32'h0);
`endif
    wr(A_CTRL, 32'h5);
    chk("ovf_o_clr", 32'(ovf), 32'h0);
    rd(A_OVF, 32'h0, "ovf_clr");

    // Read and write together: write wins, single ack.
    bus.mem_addr_i    = A_CHEN;
    bus.mem_rd_i      = 1'b1;
    bus.mem_wr_i      = 4'hF;
    bus.mem_data_wr_i = 32'h7;
    sb.push_back('{exp: 32'h0, is_rd: 1'b0, tag: "rdwr_ack"});
    @(negedge clk);
    bus.mem_rd_i = 1'b0;
    bus.mem_wr_i = 4'h0;
    rd(8'h06, 32'h7, "chen_after_rdwr");

    // Reset while counting and with a read in flight.
    wr(A_CHEN, 32'h1);
    ev = 4'b0001;
    repeat (10) @(negedge clk);
    bus.mem_addr_i = A_CTRL;
    bus.mem_rd_i   = 1'b1;
    rst_n          = 1'b0;
    @(negedge clk);
    chk("midrst_ack", 32'(bus.mem_ack_o), 32'h0);
    chk("midrst_rdata", bus.mem_data_rd_o, 32'h0);
    chk("midrst_ovf", 32'(ovf), 32'h0);
    bus.mem_rd_i = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", 32'(bus.mem_ack_o), 32'h0);
    rd(A_CTRL, 32'h0, "ctrl_after_rst");
    rd(A_CHEN, 32'h0, "chen_after_rst");
    wr(A_CTRL, 32'h3);
    rd(8'h10, 32'h0, "sh0_after_rst");
    ev = '0;

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
